// File: rtl/gates_stim_chk.sv
// Self-test sequencer for the gates block: walks the four {A,B} vectors, settles, then checks all five outputs.
// Each vector takes SETTLE+1+hold cycles, and oDone rises 4*(SETTLE+1+hold) edges after start. iStart is ignored while busy.
module gates_stim_chk #(
  parameter int SETTLE = 1,
  parameter int HOLD_W = 8,
  parameter int ERR_W  = 3
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iStart,
  input  logic [HOLD_W-1:0] iHold,
  output logic              oA,
  output logic              oB,
  input  logic              iAND,
  input  logic              iOR,
  input  logic              iNOT,
  input  logic              iNAND,
  input  logic              iNAND2,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPass,
  output logic [ERR_W-1:0]  oErrCnt,
  output logic [4:0]        oErrVec,
  output logic [1:0]        oFailIdx
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int CNT_W = (HOLD_W > SET_W) ? HOLD_W : SET_W;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [4:0]        err_vec_q, err_vec_d;
  logic [1:0]        fail_idx_q, fail_idx_d;
  logic [4:0]        exp_bits, got_bits, mism;
  logic              advance;

  // Case inequality so an X/Z from the gates under test is flagged, not silently matched.
  always_comb begin
    exp_bits = {~(idx_q[1] & idx_q[0]), ~(idx_q[1] & idx_q[0]), ~idx_q[1],
                idx_q[1] | idx_q[0], idx_q[1] & idx_q[0]};
    got_bits = {iNAND2, iNAND, iNOT, iOR, iAND};
    mism = '0;
    for (int i = 0; i < 5; i++) begin
      mism[i] = (got_bits[i] !== exp_bits[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    err_vec_d  = err_vec_q;
    fail_idx_d = fail_idx_q;
    advance    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          err_cnt_d  = '0;
          err_vec_d  = '0;
          fail_idx_d = '0;
          done_d     = 1'b0;
          hold_d     = iHold;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = S_APPLY;
        end
      end
      S_APPLY: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (mism != 5'b0) begin
          if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
          if (err_cnt_q == '0) fail_idx_d = idx_q;
          err_vec_d = err_vec_q | mism;
        end
        if (hold_q == '0) begin
          advance = 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q + CNT_W'(1) == CNT_W'(hold_q)) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Step to the next vector without spending a cycle on the decision.
    if (advance) begin
      cnt_d = '0;
      if (idx_q == 2'd3) begin
        idx_d   = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        idx_d   = idx_q + 2'd1;
        state_d = S_APPLY;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_vec_q  <= '0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      err_vec_q  <= err_vec_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign oBusy    = (state_q != S_IDLE);
  assign oA       = oBusy & idx_q[1];
  assign oB       = oBusy & idx_q[0];
  assign oDone    = done_q;
  assign oPass    = done_q & (err_cnt_q == '0);
  assign oErrCnt  = err_cnt_q;
  assign oErrVec  = err_vec_q;
  assign oFailIdx = fail_idx_q;

endmodule

// File: tb/tb_gates_stim_chk.sv
// Bench for gates_stim_chk: a faultable gates model in the loop, truth-table reference, done-triggered scoreboard.
module tb_gates_stim_chk;
  localparam int SETTLE = 1;
  localparam int HOLD_W = 8;
  localparam int ERR_W  = 3;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  logic start = 1'b0;
  logic [HOLD_W-1:0] hold = '0;
  logic a, b, busy, done, pass;
  logic g_and, g_or, g_not, g_nand, g_nand2;
  logic [ERR_W-1:0] err_cnt;
  logic [4:0] err_vec;
  logic [1:0] fail_idx;

  logic [4:0] f_en = '0;
  logic [4:0] f_val = '0;
  logic       f_x = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         errcnt;
    logic [4:0] errvec;
    int         failidx;
    int         pass;
    int         latency;
    int         vlen;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Golden truth table, bits {NAND2,NAND,NOT,OR,AND}, indexed by vector {A,B}.
  function automatic logic [4:0] ideal(input int v);
    case (v)
      0: return 5'b11100;
      1: return 5'b11110;
      2: return 5'b11010;
      default: return 5'b00011;
    endcase
  endfunction

  // Gates device with stuck-at and X injection.
  function automatic logic [4:0] env_gates(input int v, input logic [4:0] en,
                                           input logic [4:0] val, input logic xa);
    logic [4:0] r;
    r = (ideal(v) & ~en) | (val & en);
    if (xa) r[0] = 1'bx;
    return r;
  endfunction

  assign {g_nand2, g_nand, g_not, g_or, g_and} = env_gates(int'({a, b}), f_en, f_val, f_x);

  function automatic exp_t predict(input int h, input logic [4:0] en,
                                   input logic [4:0] val, input logic xa);
    exp_t e;
    int cnt;
    logic [4:0] obs, ref_bits, m;
    cnt = 0;
    e.errvec = '0;
    e.failidx = 0;
    for (int v = 0; v < 4; v++) begin
      obs = env_gates(v, en, val, xa);
      ref_bits = ideal(v);
      m = '0;
      for (int i = 0; i < 5; i++) if (obs[i] !== ref_bits[i]) m[i] = 1'b1;
      if (m != 5'b0) begin
        if (cnt == 0) e.failidx = v;
        cnt++;
        e.errvec |= m;
      end
    end
    e.errcnt  = (cnt > (2**ERR_W - 1)) ? (2**ERR_W - 1) : cnt;
    e.pass    = (cnt == 0) ? 1 : 0;
    e.vlen    = SETTLE + 1 + h;
    e.latency = 4 * e.vlen;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, expv, $time);
    end
  endtask

  gates_stim_chk #(.SETTLE(SETTLE), .HOLD_W(HOLD_W), .ERR_W(ERR_W)) dut (
    .iClk(clk), .iRsn(rsn), .iStart(start), .iHold(hold),
    .oA(a), .oB(b),
    .iAND(g_and), .iOR(g_or), .iNOT(g_not), .iNAND(g_nand), .iNAND2(g_nand2),
    .oBusy(busy), .oDone(done), .oPass(pass),
    .oErrCnt(err_cnt), .oErrVec(err_vec), .oFailIdx(fail_idx)
  );

  // Monitor: records the vector trace of each run and scores it when oDone rises.
  initial begin
    bit busy_prev, done_prev, tracking;
    int cyc, cur_len;
    logic [1:0] cur_v;
    int vseq[$];
    int lseq[$];
    exp_t e;
    busy_prev = 0; done_prev = 0; tracking = 0; cyc = 0; cur_len = 0; cur_v = '0;
    forever begin
      @(negedge clk);
      if (!rsn) begin
        busy_prev = 0; done_prev = 0; tracking = 0;
        continue;
      end
      if (busy) chk("pass_while_busy", pass, 0);
      else      chk("idle_ab_zero", {a, b}, 0);
      if (busy && !busy_prev) begin
        tracking = 1; cyc = 0; cur_v = {a, b}; cur_len = 1;
        vseq.delete(); lseq.delete();
      end else if (tracking) begin
        cyc++;
        if (busy) begin
          if ({a, b} == cur_v) cur_len++;
          else begin
            vseq.push_back(int'(cur_v)); lseq.push_back(cur_len);
            cur_v = {a, b}; cur_len = 1;
          end
        end else if (busy_prev) begin
          vseq.push_back(int'(cur_v)); lseq.push_back(cur_len);
        end
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_latency", cyc, e.latency);
          chk("vector_count", vseq.size(), 4);
          for (int i = 0; i < vseq.size() && i < 4; i++) begin
            chk("vector_order", vseq[i], i);
            chk("vector_len", lseq[i], e.vlen);
          end
          chk("err_cnt", err_cnt, e.errcnt);
          chk("err_vec", err_vec, e.errvec);
          if (e.errcnt != 0) chk("fail_idx", fail_idx, e.failidx);
          chk("pass", pass, e.pass);
          chk("busy_at_done", busy, 0);
        end
        tracking = 0;
      end
      busy_prev = busy;
      done_prev = done;
    end
  end

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_timeout", seen, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_seq(input int h, input logic [4:0] en, input logic [4:0] val,
                         input logic xa, input bit poke);
    f_en = en; f_val = val; f_x = xa;
    exp_q.push_back(predict(h, en, val, xa));
    @(negedge clk);
    start = 1'b1; hold = HOLD_W'(h);
    @(negedge clk);
    start = 1'b0; hold = HOLD_W'($urandom);
    chk("start_clears_done", done, 0);
    chk("start_clears_cnt", err_cnt, 0);
    chk("start_clears_vec", err_vec, 0);
    chk("busy_after_start", busy, 1);
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cnt", err_cnt, 0);
    chk("rst_ab", {a, b}, 0);
    #2 rsn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", busy, 0);

    run_seq(0, 5'b00000, 5'b00000, 1'b0, 0);
    run_seq(3, 5'b00000, 5'b00000, 1'b0, 0);
    run_seq(0, 5'b00100, 5'b00000, 1'b0, 0);   // NOT stuck at 0
    run_seq(1, 5'b10000, 5'b10000, 1'b0, 0);   // NAND2 tied high
    run_seq(0, 5'b00000, 5'b00000, 1'b1, 0);   // AND driven X
    run_seq(2, 5'b00000, 5'b00000, 1'b0, 1);   // start poked mid-run

    // Asynchronous reset while vector 10 is applied.
    f_en = '0; f_x = 1'b0;
    @(negedge clk); start = 1'b1; hold = 8'd2;
    @(negedge clk); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if ({a, b} == 2'b10 && busy) hit = 1;
      else @(negedge clk);
    end
    chk("reach_vec10", hit, 1);
    #2 rsn = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ab", {a, b}, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_flags", {pass, err_cnt, err_vec, fail_idx}, 0);
    repeat (2) @(negedge clk);
    #2 rsn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_midrun_rst", busy, 0);
    run_seq(0, 5'b00000, 5'b00000, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      run_seq(int'($urandom_range(0, 4)), 5'($urandom & $urandom), 5'($urandom),
              1'b0, bit'($urandom_range(0, 1)));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gates_stim_chk.md
Name: gates_stim_chk

Overview:
- Sequential stimulus generator and response checker that sits directly upstream of the `gates` block.
- Walks the 2-input truth table (iA,iB = 00, 01, 10, 11), drives the gate inputs, waits a settle time, then samples and compares all five gate outputs against expected values.
- Reports pass/fail, error count, error bitmap and first failing vector.
- Gives the `gates` block a synthesizable on-chip self-test and replaces the hand-written bench sequence.

Parameters:
- SETTLE, 1, cycles each vector is driven before outputs are sampled (>=1).
- HOLD_W, 8, width of the per-vector extra-hold count input.
- ERR_W, 3, width of the error counter (saturating).

Ports:
- iClk  input  1  clock, rising edge.
- iRsn  input  1  asynchronous active-low reset.
- iStart  input  1  start request; one-cycle pulse or level.
- iHold  input  HOLD_W  extra idle cycles after each check; latched at start.
- oA  output  1  drives `gates` iA.
- oB  output  1  drives `gates` iB.
- iAND, iOR, iNOT, iNAND, iNAND2  input  1 each  returned `gates` outputs.
- oBusy  output  1  sequence in progress.
- oDone  output  1  sequence finished; sticky until next accepted start or reset.
- oPass  output  1  oDone & (oErrCnt==0).
- oErrCnt  output  ERR_W  number of failing vectors, saturates at all-ones.
- oErrVec  output  5  sticky OR of mismatch bits {NAND2,NAND,NOT,OR,AND}.
- oFailIdx  output  2  index {A,B} of first failing vector; valid when oErrCnt!=0.

Behaviour:
- Reset (iRsn=0, asynchronous): state IDLE, idx=0, all counters 0, all outputs 0. Reset takes effect immediately at any point, including mid-sequence. After release the block stays in IDLE until a new iStart.
- States:
  - IDLE: oBusy=0, oA=oB=0. iStart=1 sampled at edge k: clear oErrCnt, oErrVec, oFailIdx and oDone; latch iHold; idx=0; go to APPLY.
  - APPLY: oA=idx[1], oB=idx[0], both derived from registers only (no combinational path from any input). Stays SETTLE cycles, then goes to CHECK.
  - CHECK (1 cycle): oA/oB still driven. Expected values: AND=a&b, OR=a|b, NOT=~a, NAND=NAND2=~(a&b). Compare with case inequality, so X or Z on an input counts as a mismatch. If any bit mismatches:
    - oErrCnt increments (saturating);
    - oErrVec |= mismatch bits;
    - oFailIdx = idx if this is the first failure.
    - Then: latched hold==0 goes to NEXT, otherwise go to HOLD.
  - HOLD: oA/oB held; count latched hold cycles, then go to NEXT.
  - NEXT (combinational decision, no extra cycle): if idx==3, go to IDLE with oDone=1 and oBusy=0; otherwise idx++ and go to APPLY.
- oBusy is 1 in APPLY, CHECK and HOLD.
- Timing from the accepting edge k: each vector lasts SETTLE+1+H cycles. oDone rises at edge k+4*(SETTLE+1+H). With defaults and H=0 that is k+8.
- iStart while oBusy=1 is ignored. iStart with oDone=1 restarts the sequence and clears oDone at the accepting edge.
- iHold changes during a run have no effect.
- oPass = oDone & (oErrCnt==0). oPass is 0 while busy and before the first run.

Test Plan:
- Connect a real `gates` instance, reset, pulse iStart, iHold=0 -> oA/oB sequence 00,01,10,11 with each vector held 2 cycles; oDone=1 and oPass=1 exactly 8 cycles after the start edge; oErrCnt=0, oErrVec=00000.
- Same setup with iHold=3 -> each vector held 5 cycles; oDone at +20; oPass=1.
- Force iNOT stuck at 0 -> vectors 00 and 01 fail; oErrCnt=2, oErrVec=00100, oFailIdx=0, oPass=0.
- Tie iNAND2 to 1 -> only vector 11 fails; oErrCnt=1, oErrVec=10000, oFailIdx=3. Drive iAND=X -> counted as a mismatch.
- Pulse iStart again during the run -> ignored, and timing is unchanged. Pulse iStart after oDone -> flags clear on the accepting edge and the sequence reruns.
- Drop iRsn while on vector 10 -> all outputs go to 0 immediately without waiting for a clock edge. After release, oBusy stays 0 until iStart; a full rerun then passes.
